// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM stage: FSM states, WB control bit
// positions and the MEM/WB bubble values.
package mem_access_stage_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned WB_REGWRITE = 0;
   localparam int unsigned WB_MEMTOREG = 1;

   localparam logic [1:0]  BUBBLE_WB   = '0;
   localparam logic [4:0]  BUBBLE_RD   = '0;
   localparam logic [31:0] BUBBLE_DATA = '0;

endpackage

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register: every edge it captures either the presented
// instruction fields or a bubble.
module mem_wb_reg
   import mem_access_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bubble,
   input  logic [1:0]  next_wb,
   input  logic [4:0]  next_rd,
   input  logic [31:0] next_alu,
   input  logic [31:0] next_mem,
   output logic [1:0]  wb,
   output logic [4:0]  rd,
   output logic [31:0] alu_data,
   output logic [31:0] mem_data
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb       <= '0;
         rd       <= '0;
         alu_data <= '0;
         mem_data <= '0;
      end else if (bubble) begin
         wb       <= BUBBLE_WB;
         rd       <= BUBBLE_RD;
         alu_data <= BUBBLE_DATA;
         mem_data <= BUBBLE_DATA;
      end else begin
         wb       <= next_wb;
         rd       <= next_rd;
         alu_data <= next_alu;
         mem_data <= next_mem;
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: req/ack handshake to a variable-latency data memory, upstream
// stall generation, timeout/error tracking and the MEM/WB register.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [1:0]  wb_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [4:0]  rd_addr_i,
   input  logic [31:0] alu_data_i,
   input  logic [31:0] wdata_i,
   output logic        stall_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   input  logic [31:0] dmem_rdata_i,
   input  logic        dmem_ack_i,
   output logic [1:0]  wb_o,
   output logic        fw_o,
   output logic [4:0]  rd_addr_o,
   output logic [31:0] alu_data_o,
   output logic [31:0] mem_data_o,
   output logic        err_o
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

   state_t        state, next_state;
   logic [CW-1:0] cnt;
   logic          access, aligned, timeout;
   logic          issue, finish, set_err, bubble;
   logic [1:0]    next_wb;
   logic [31:0]   next_mem;

   assign access  = mem_read_i | mem_write_i;
   assign aligned = (alu_data_i[1:0] == 2'b00);
   assign timeout = (cnt == CNT_LAST);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (access && aligned) next_state = BUSY;
         BUSY:    if (dmem_ack_i || timeout) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Ack is tested before timeout so a same-cycle ack completes normally.
   always_comb begin
      stall_o  = 1'b0;
      issue    = 1'b0;
      finish   = 1'b0;
      set_err  = 1'b0;
      bubble   = 1'b1;
      next_wb  = wb_i;
      next_mem = BUBBLE_DATA;
      case (state)
         IDLE: begin
            if (!access) begin
               bubble = 1'b0;
            end else if (aligned) begin
               stall_o = 1'b1;
               issue   = 1'b1;
               set_err = mem_read_i & mem_write_i;
            end else begin
               bubble               = 1'b0;
               next_wb[WB_REGWRITE] = 1'b0;
               next_wb[WB_MEMTOREG] = 1'b0;
               set_err              = 1'b1;
            end
         end
         BUSY: begin
            stall_o = 1'b1;
            if (dmem_ack_i) begin
               finish   = 1'b1;
               bubble   = 1'b0;
               next_mem = dmem_we_o ? BUBBLE_DATA : dmem_rdata_i;
            end else if (timeout) begin
               finish               = 1'b1;
               bubble               = 1'b0;
               next_wb[WB_REGWRITE] = 1'b0;
               next_wb[WB_MEMTOREG] = 1'b0;
               set_err              = 1'b1;
            end
         end
         default: ;
      endcase
      if (!rst_n_i) stall_o = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         dmem_req_o   <= 1'b0;
         dmem_we_o    <= 1'b0;
         dmem_addr_o  <= '0;
         dmem_wdata_o <= '0;
         err_o        <= 1'b0;
         cnt          <= '0;
      end else begin
         if (issue) begin
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= mem_write_i;
            dmem_addr_o  <= {alu_data_i[31:2], 2'b00};
            dmem_wdata_o <= wdata_i;
         end else if (finish) begin
            dmem_req_o <= 1'b0;
         end
         if (set_err) err_o <= 1'b1;
         cnt <= (state == BUSY) ? cnt + CW'(1) : '0;
      end
   end

   mem_wb_reg u_mem_wb (
      .clk      (clk_i),
      .rst_n    (rst_n_i),
      .bubble   (bubble),
      .next_wb  (next_wb),
      .next_rd  (rd_addr_i),
      .next_alu (alu_data_i),
      .next_mem (next_mem),
      .wb       (wb_o),
      .rd       (rd_addr_o),
      .alu_data (alu_data_o),
      .mem_data (mem_data_o)
   );

   assign fw_o = wb_o[WB_REGWRITE];

endmodule
